// File: rtl/tt_pkg.sv
// ----------------------------------------------------------------------------
// tt_pkg
// Shared definitions for the truth-table checker: FSM state encoding, vector
// count and the widths of the vector index, settle counter and error counter.
// No ports (package).
// ----------------------------------------------------------------------------
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tt_state_t;

   localparam int VEC_COUNT = 4;   // vectors in a 2-input sweep
   localparam int IDX_W     = 2;   // vector index width, idx = {a,b}
   localparam int CNT_W     = 4;   // settle counter width, holds 1..15
   localparam int ERR_W     = 3;   // mismatch counter width, holds 0..4

endpackage

// File: rtl/settle_timer.sv
// ----------------------------------------------------------------------------
// settle_timer
// Down-counter that paces how long each input vector is held before the
// checker samples the gate network output.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset, clears the count
//   i_load    : load the count with SETTLE_CYCLES
//   i_dec     : decrement the count by one (ignored while loading)
//   o_expire  : high during the last settle cycle of the current vector
// ----------------------------------------------------------------------------
module settle_timer
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_dec,
   output logic o_expire
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CNT_W'(SETTLE_CYCLES);
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   // The count reads SETTLE_CYCLES in the first settle cycle, so the value 1
   // marks the last one. Treating 0 as expired as well keeps the FSM from
   // stalling should the counter ever be found empty while settling.
   assign o_expire = (r_count <= CNT_W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// ----------------------------------------------------------------------------
// truth_table_checker
// Drives all four {a,b} input combinations into a 2-input gate network, holds
// each for SETTLE_CYCLES cycles, samples the network output once and compares
// it against the expected truth table latched at start.
// Ports:
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   start         : one-cycle sweep request, accepted only in IDLE
//   expected[3:0] : expected output per vector, bit index = {a,b}
//   dut_out       : output of the gate network under check
//   dut_a, dut_b  : registered drive to the network inputs (idx[1], idx[0])
//   busy          : sweep in progress (SETTLE, SAMPLE, DONE)
//   done          : one-cycle pulse in the DONE state
//   pass          : last completed sweep had no mismatches
//   mismatch_mask : bit i set when vector i mismatched in the last sweep
//   err_count     : number of mismatches in the last sweep, 0..4
// ----------------------------------------------------------------------------
module truth_table_checker
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [VEC_COUNT-1:0] expected,
   input  logic                 dut_out,
   output logic                 dut_a,
   output logic                 dut_b,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [VEC_COUNT-1:0] mismatch_mask,
   output logic [ERR_W-1:0]     err_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(VEC_COUNT);

   tt_state_t            r_state;
   tt_state_t            w_state_next;
   logic [IDX_W-1:0]     r_idx;
   logic [VEC_COUNT-1:0] r_expected;
   logic [VEC_COUNT-1:0] r_mask;
   logic [ERR_W-1:0]     r_err;
   logic                 r_pass;

   logic w_load;
   logic w_dec;
   logic w_expire;
   logic w_mismatch;

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_dec    (w_dec),
      .o_expire (w_expire)
   );

   assign w_mismatch = (dut_out != r_expected[r_idx]);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and timer control
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_dec        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = SETTLE;
               w_load       = 1'b1;
            end
         end
         SETTLE: begin
            w_dec = 1'b1;
            if (w_expire) begin
               w_state_next = SAMPLE;
            end
         end
         SAMPLE: begin
            if (r_idx == LAST_IDX) begin
               w_state_next = DONE;
            end else begin
               w_state_next = SETTLE;
               w_load       = 1'b1;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Sweep datapath: vector index, latched table and results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_expected <= '0;
         r_mask     <= '0;
         r_err      <= '0;
         r_pass     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx      <= '0;
                  r_expected <= expected;
                  r_mask     <= '0;
                  r_err      <= '0;
                  r_pass     <= 1'b0;
               end
            end
            SAMPLE: begin
               if (w_mismatch) begin
                  r_mask[r_idx] <= 1'b1;
                  if (r_err != ERR_MAX) begin
                     r_err <= r_err + ERR_W'(1);
                  end
               end
               if (r_idx != LAST_IDX) begin
                  r_idx <= r_idx + IDX_W'(1);
               end else begin
                  // Verdict is taken on the way into DONE so that pass is
                  // already valid while done is high; the final sample is
                  // folded in here since r_mask has not absorbed it yet.
                  r_pass <= (r_mask == '0) && !w_mismatch;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // idx is itself a register, so the drive is registered and stays at 1,1
   // after the last vector until the next accepted start.
   assign dut_a         = r_idx[1];
   assign dut_b         = r_idx[0];
   assign busy          = (r_state != IDLE);
   assign done          = (r_state == DONE);
   assign pass          = r_pass;
   assign mismatch_mask = r_mask;
   assign err_count     = r_err;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

   typedef struct {
      int       done_cyc;
      bit [3:0] mask;
      int       err;
      bit       pass;
   } sweep_t;

   typedef struct {
      int       inst;
      int       cyc;
      bit       all_zero;
      bit [1:0] ab;
      bit       busy;
   } chk_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_s  [2];
   logic [3:0] exp_s    [2];
   logic [3:0] net_s    [2];
   logic       dout_s   [2];
   logic       dut_a_s  [2];
   logic       dut_b_s  [2];
   logic       busy_s   [2];
   logic       done_s   [2];
   logic       pass_s   [2];
   logic [3:0] mask_s   [2];
   logic [2:0] err_s    [2];

   sweep_t sb0[$];
   sweep_t sb1[$];
   chk_t   chk_q[$];
   int     busy_until [2];
   int     cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   bit     end_req = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      // Gate network under check: a lookup table indexed by {a,b}
      assign dout_s[gi] = net_s[gi][{dut_a_s[gi], dut_b_s[gi]}];

      truth_table_checker #(
         .SETTLE_CYCLES (gi == 0 ? 2 : 1)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .start         (start_s[gi]),
         .expected      (exp_s[gi]),
         .dut_out       (dout_s[gi]),
         .dut_a         (dut_a_s[gi]),
         .dut_b         (dut_b_s[gi]),
         .busy          (busy_s[gi]),
         .done          (done_s[gi]),
         .pass          (pass_s[gi]),
         .mismatch_mask (mask_s[gi]),
         .err_count     (err_s[gi])
      );
   end

   function automatic int s_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   // ---------------- monitor / scoreboard (sole owner of the counters) -----
   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (done_s[i]) begin
            if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
               chk($sformatf("unexpected_done_inst%0d", i), 1, 0);
            end else begin
               sweep_t r;
               r = (i == 0) ? sb0.pop_front() : sb1.pop_front();
               chk($sformatf("done_cycle_inst%0d", i), cyc, r.done_cyc);
               chk($sformatf("mask_inst%0d", i), int'(mask_s[i]), int'(r.mask));
               chk($sformatf("err_count_inst%0d", i), int'(err_s[i]), r.err);
               chk($sformatf("pass_inst%0d", i), int'(pass_s[i]), int'(r.pass));
               $display("sweep inst=%0d cyc=%0d mask=%b err=%0d pass=%0d", i, cyc,
                        mask_s[i], err_s[i], pass_s[i]);
            end
         end
      end
      for (int j = chk_q.size() - 1; j >= 0; j--) begin
         if (chk_q[j].cyc == cyc) begin
            int ii;
            ii = chk_q[j].inst;
            if (chk_q[j].all_zero) begin
               chk($sformatf("reset_outputs_inst%0d", ii),
                   int'({dut_a_s[ii], dut_b_s[ii], busy_s[ii], done_s[ii],
                         pass_s[ii], mask_s[ii], err_s[ii]}), 0);
               $display("reset check inst=%0d cyc=%0d", ii, cyc);
            end else begin
               chk($sformatf("drive_ab_busy_inst%0d", ii),
                   int'({dut_a_s[ii], dut_b_s[ii], busy_s[ii]}),
                   int'({chk_q[j].ab, chk_q[j].busy}));
               $display("drive check inst=%0d cyc=%0d ab=%b%b busy=%0d", ii, cyc,
                        dut_a_s[ii], dut_b_s[ii], busy_s[ii]);
            end
            chk_q.delete(j);
         end
      end
      if (end_req) begin
         chk("queues_drained", sb0.size() + sb1.size() + chk_q.size(), 0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic push_chk(input int i, input int c, input bit z, input bit [1:0] ab, input bit b);
      chk_t e;
      e.inst = i; e.cyc = c; e.all_zero = z; e.ab = ab; e.busy = b;
      chk_q.push_back(e);
   endtask

   // Issue a one-cycle start; the reference model decides acceptance from
   // whether the instance is idle, and derives results from the tables.
   task automatic pulse(input int i, input bit [3:0] e, input bit [3:0] n);
      int t;
      t = cyc;
      start_s[i] = 1'b1;
      exp_s[i]   = e;
      if (rst_n && (t > busy_until[i])) begin
         sweep_t r;
         net_s[i]   = n;
         r.mask     = e ^ n;
         r.err      = $countones(e ^ n);
         r.pass     = ((e ^ n) == 4'b0000);
         r.done_cyc = t + 1 + 4 * (s_of(i) + 1);
         busy_until[i] = r.done_cyc;
         if (i == 0) sb0.push_back(r); else sb1.push_back(r);
         $display("start inst=%0d cyc=%0d expected=%b net=%b accepted", i, t, e, n);
      end else begin
         $display("start inst=%0d cyc=%0d expected=%b ignored", i, t, e);
      end
      tick(1);
      start_s[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      while (cyc <= busy_until[i]) tick(1);
   endtask

   initial begin
      int t0;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         exp_s[i]   = 4'b0000;
         net_s[i]   = 4'b1111;
         busy_until[i] = 0;
      end
      push_chk(0, 2, 1'b1, 2'b00, 1'b0);
      push_chk(1, 2, 1'b1, 2'b00, 1'b0);
      tick(3);
      rst_n = 1'b1;
      busy_until[0] = cyc; busy_until[1] = cyc;
      tick(2);

      // Constant-true network against several tables
      pulse(0, 4'b1111, 4'b1111); wait_idle(0);
      pulse(0, 4'b0110, 4'b1111); wait_idle(0);
      pulse(0, 4'b0000, 4'b1111); wait_idle(0);

      // Drive sequence on the SETTLE_CYCLES=1 instance
      t0 = cyc;
      for (int k = 0; k < 8; k++) push_chk(1, t0 + 1 + k, 1'b0, 2'(k / 2), 1'b1);
      push_chk(1, t0 + 9, 1'b0, 2'b11, 1'b1);
      push_chk(1, t0 + 10, 1'b0, 2'b11, 1'b0);
      pulse(1, 4'b1001, 4'b1011); wait_idle(1);
      tick(2);

      // Re-pulse of start and change of expected during a sweep
      pulse(0, 4'b0101, 4'b1111);
      tick(3);
      pulse(0, 4'b0000, 4'b0000);
      exp_s[0] = 4'b1111;
      wait_idle(0);

      // start in the DONE cycle is ignored, accepted one cycle later
      pulse(0, 4'b1000, 4'b1000);
      while (cyc < busy_until[0]) tick(1);
      pulse(0, 4'b0011, 4'b0000);
      pulse(0, 4'b0011, 4'b0000);
      wait_idle(0);

      // Reset mid-sweep, with start asserted alongside the reset
      t0 = cyc;
      pulse(0, 4'b1111, 4'b1110);
      tick(6);
      push_chk(0, t0 + 8, 1'b1, 2'b00, 1'b0);
      rst_n = 1'b0;
      start_s[0] = 1'b1;
      sb0.delete(); sb1.delete();
      busy_until[0] = cyc; busy_until[1] = cyc;
      $display("reset asserted cyc=%0d", cyc);
      tick(1);
      rst_n = 1'b1;
      start_s[0] = 1'b0;
      tick(20);
      pulse(0, 4'b1010, 4'b1010); wait_idle(0);

      // Randomized sweeps on both instances
      for (int k = 0; k < 40; k++) begin
         int i;
         i = $urandom_range(0, 1);
         pulse(i, 4'($urandom), 4'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(0, 6));
            pulse(i, 4'($urandom), 4'($urandom));
         end
         if ($urandom_range(0, 1) == 0) exp_s[i] = 4'($urandom);
         tick($urandom_range(0, 12));
      end

      for (int w = 0; (w < 400) && ((sb0.size() + sb1.size() + chk_q.size()) != 0); w++) tick(1);
      end_req = 1'b1;
   end

endmodule
